lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  Load/store initiator between core execute stage and a memory responder (ROM/RAM) using the
//  ce/req/gnt handshake with hb size encoding. Accepts one access at a time, checks alignment,
//  drives req until gnt, sign/zero-extends returned load data, builds byte lanes for stores.
//  Responder returns loads right-justified and zero-extended per hb; all extension happens here.
// PARAMETERS
//  TIMEOUT  16  max REQ cycles without gnt before bus error; 0 = wait forever
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_ni          in   1   asynchronous active-low reset
//  lsu_valid_i     in   1   core access request, sampled when lsu_ready_o=1
//  lsu_we_i        in   1   1=store, 0=load
//  lsu_size_i      in   2   00 byte, 01 half, 10/11 word
//  lsu_unsigned_i  in   1   1=zero-extend load (LBU/LHU), 0=sign-extend
//  lsu_addr_i      in   32  byte address
//  lsu_wdata_i     in   32  store data, right-justified
//  lsu_ready_o     out  1   block idle, can accept
//  lsu_done_o      out  1   one-cycle completion pulse
//  lsu_err_o       out  1   valid with done: misaligned or timeout
//  lsu_rdata_o     out  32  extended load data, held until next accept
//  mem_ce_o        out  1   chip enable
//  mem_req_o       out  1   request
//  mem_gnt_i       in   1   grant (may be combinational from req&ce)
//  mem_we_o        out  1   write strobe
//  mem_addr_o      out  32  byte address
//  mem_hb_o        out  2   size, same encoding as lsu_size_i
//  mem_wdata_o     out  32  store data replicated to lanes
//  mem_be_o        out  4   byte enables (stores); 0 on loads
//  mem_rdata_i     in   32  load data from responder
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; lsu_ready_o=1; done/err=0; rdata=0; all mem_* outputs 0;
//   timeout counter 0. Reset mid-access drops the access, no done pulse.
//  States: IDLE, REQ, RESP.
//  IDLE: ready=1. valid&ready: latch we/size/unsigned/addr/wdata. Misaligned (half with addr[0]=1,
//   word with addr[1:0]!=0) -> RESP with err=1, no mem access. Else -> REQ, counter cleared.
//  REQ: ready=0; ce=req=1; mem_addr/hb/we/wdata/be driven from latched regs, stable until gnt.
//   gnt=1: load captures mem_rdata_i, extended (byte from bit7, half from bit15 unless unsigned;
//   word as-is) into lsu_rdata_o; -> RESP err=0. Store: rdata unchanged.
//   gnt=0: counter++; TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP err=1, req drops next cycle.
//   gnt and timeout same cycle: gnt wins (no error).
//  RESP: done=1 for exactly one cycle, err as set; ready=0; -> IDLE. New valid accepted
//   earliest cycle after RESP.
//  Latency (gnt same cycle as req): accept edge T, req high T+1, done high T+2; 2-cycle min.
//  Store lanes: byte -> wdata={4{b[7:0]}}, be=0001<<addr[1:0]; half -> {2{b[15:0]}},
//   be=0011<<addr[1:0]; word -> wdata as-is, be=1111.
//  mem_* outputs are registered; all 0 outside REQ. lsu_valid_i ignored when ready=0.
// TESTING
//  LB addr 0x03, mem_rdata=0x000000F0, gnt same cycle -> done at T+2, rdata=0xFFFFFFF0, err=0.
//  LHU addr 0x02, rdata_i=0x00008001 -> rdata=0x00008001; LH same -> 0xFFFF8001.
//  SB addr 0x01, wdata=0x123456AB -> REQ: we=1, be=0010, mem_wdata=0xABABABAB, hb=00.
//  LW addr 0x06 -> no req ever asserted, done+err next-after-accept cycle.
//  TIMEOUT=4, gnt held 0 -> req high 4 cycles, then done+err; gnt on 4th cycle -> no err.
//  Assert rst_ni=0 during REQ -> mem_req_o=0 immediately, no done; ready=1 after release.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// Core-side LSU handshake plus ce/req/gnt memory bus; master = the initiator block.
// slave = the core and responder side, as seen from outside the initiator.
interface lsu_bus_master_if;
  logic        lsu_valid;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_ce;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_hb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  modport master (
    input  lsu_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_done, lsu_err, lsu_rdata,
    output mem_ce, mem_req, mem_we, mem_addr, mem_hb, mem_wdata, mem_be,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    output lsu_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_done, lsu_err, lsu_rdata,
    input  mem_ce, mem_req, mem_we, mem_addr, mem_hb, mem_wdata, mem_be,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator: done 2 cycles after accept when gnt is immediate.
// Backpressure: ready only in IDLE; req held with stable payload until gnt or timeout.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  lsu_bus_master_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;

  logic          mem_ce_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [1:0]    mem_hb_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_be_q;

  logic          accept;
  logic          misaligned;
  logic          gnt_hit;
  logic          timeout_hit;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_be;
  logic [31:0]   load_ext;

  assign accept     = bus.lsu_valid && (state_q == IDLE);
  assign misaligned = ((bus.lsu_size == 2'b01) && bus.lsu_addr[0]) ||
                      (bus.lsu_size[1] && (bus.lsu_addr[1:0] != 2'b00));
  assign gnt_hit     = (state_q == REQ) && bus.mem_gnt;
  // gnt takes priority over an expiring counter in the same cycle
  assign timeout_hit = (state_q == REQ) && !bus.mem_gnt &&
                       (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    lane_wdata = bus.lsu_wdata;
    lane_be    = 4'b1111;
    case (bus.lsu_size)
      2'b00: begin
        lane_wdata = {4{bus.lsu_wdata[7:0]}};
        lane_be    = 4'b0001 << bus.lsu_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{bus.lsu_wdata[15:0]}};
        lane_be    = 4'b0011 << bus.lsu_addr[1:0];
      end
      default: ;
    endcase
  end

  // Responder zero-extends; sign comes from the top bit of the returned width
  always_comb begin
    load_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      2'b01:   load_ext = {{16{~uns_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.lsu_ready = 1'b0;
    bus.lsu_done  = 1'b0;
    bus.lsu_err   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.lsu_ready = 1'b1;
        if (accept) state_d = misaligned ? RESP : REQ;
      end
      REQ: begin
        if (gnt_hit || timeout_hit) state_d = RESP;
      end
      RESP: begin
        bus.lsu_done = 1'b1;
        bus.lsu_err  = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_ce_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_hb_q    <= 2'b00;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
    end else if (accept) begin
      we_q   <= bus.lsu_we;
      size_q <= bus.lsu_size;
      uns_q  <= bus.lsu_unsigned;
      err_q  <= misaligned;
      cnt_q  <= '0;
      if (!misaligned) begin
        mem_ce_q    <= 1'b1;
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.lsu_we;
        mem_addr_q  <= bus.lsu_addr;
        mem_hb_q    <= bus.lsu_size;
        mem_wdata_q <= bus.lsu_we ? lane_wdata : 32'h0;
        mem_be_q    <= bus.lsu_we ? lane_be : 4'b0000;
      end
    end else if (gnt_hit || timeout_hit) begin
      err_q       <= timeout_hit;
      if (gnt_hit && !we_q) rdata_q <= load_ext;
      mem_ce_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_hb_q    <= 2'b00;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
    end else if (state_q == REQ) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.lsu_rdata = rdata_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_hb    = mem_hb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: vector table for single accesses, hand sequences for
// timeout, late grant and reset during a request.
module tb_lsu_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gnt_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   req_cycles;

  lsu_bus_master_if bus_if ();

  lsu_bus_master #(.TIMEOUT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.mem_gnt = bus_if.mem_req & bus_if.mem_ce & gnt_en;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrdata);
    bus_if.lsu_valid    = 1'b1;
    bus_if.lsu_we       = we;
    bus_if.lsu_size     = size;
    bus_if.lsu_unsigned = uns;
    bus_if.lsu_addr     = addr;
    bus_if.lsu_wdata    = wdata;
    bus_if.mem_rdata    = mrdata;
  endtask

  initial begin
    //            we    size   uns   addr          wdata         mrdata        req   be       mwdata        err   rdata
    vec[0]  = '{1'b0, 2'b00, 1'b0, 32'h00000003, 32'h0,        32'h000000F0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFF0};
    vec[1]  = '{1'b0, 2'b01, 1'b1, 32'h00000002, 32'h0,        32'h00008001, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00008001};
    vec[2]  = '{1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0,        32'h00008001, 1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFF8001};
    vec[3]  = '{1'b1, 2'b00, 1'b0, 32'h00000001, 32'h123456AB, 32'hFFFFFFFF, 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 32'hFFFF8001};
    vec[4]  = '{1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'h12345678, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hFFFF8001};
    vec[5]  = '{1'b0, 2'b00, 1'b1, 32'h00000000, 32'h0,        32'h00000080, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00000080};
    vec[6]  = '{1'b1, 2'b01, 1'b0, 32'h00000002, 32'hCAFE1234, 32'hFFFFFFFF, 1'b1, 4'b1100, 32'h12341234, 1'b0, 32'h00000080};
    vec[7]  = '{1'b1, 2'b10, 1'b0, 32'h00000008, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h00000080};
    vec[8]  = '{1'b0, 2'b01, 1'b0, 32'h00000001, 32'h0,        32'h0000FFFF, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h00000080};
    vec[9]  = '{1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0,        32'h89ABCDEF, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h89ABCDEF};
    vec[10] = '{1'b0, 2'b00, 1'b0, 32'h00000001, 32'h0,        32'h0000007F, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0000007F};
    vec[11] = '{1'b1, 2'b11, 1'b0, 32'h00000004, 32'h01020304, 32'hFFFFFFFF, 1'b1, 4'b1111, 32'h01020304, 1'b0, 32'h0000007F};
    vec[12] = '{1'b1, 2'b00, 1'b0, 32'h00000003, 32'h00000055, 32'hFFFFFFFF, 1'b1, 4'b1000, 32'h55555555, 1'b0, 32'h0000007F};

    bus_if.lsu_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    bus_if.lsu_valid = 1'b0;

    #2;
    chk("rst_ready", {31'h0, bus_if.lsu_ready}, 32'd1);
    chk("rst_done",  {31'h0, bus_if.lsu_done},  32'd0);
    chk("rst_err",   {31'h0, bus_if.lsu_err},   32'd0);
    chk("rst_rdata", bus_if.lsu_rdata, 32'h0);
    chk("rst_mem",   {bus_if.mem_ce, bus_if.mem_req, bus_if.mem_we, bus_if.mem_hb, bus_if.mem_be},  32'h0);
    chk("rst_maddr", bus_if.mem_addr | bus_if.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'h0, bus_if.lsu_ready}, 32'd1);
      chk($sformatf("v%0d_idle_done", i), {31'h0, bus_if.lsu_done}, 32'd0);
      drive(vec[i].we, vec[i].size, vec[i].uns, vec[i].addr, vec[i].wdata, vec[i].mrdata);
      gnt_en = 1'b1;
      @(negedge clk);
      bus_if.lsu_valid = 1'b0;
      if (vec[i].exp_req) begin
        chk($sformatf("v%0d_req", i),  {30'h0, bus_if.mem_ce, bus_if.mem_req}, 32'd3);
        chk($sformatf("v%0d_we", i),   {31'h0, bus_if.mem_we}, {31'h0, vec[i].we});
        chk($sformatf("v%0d_addr", i), bus_if.mem_addr, vec[i].addr);
        chk($sformatf("v%0d_hb", i),   {30'h0, bus_if.mem_hb}, {30'h0, vec[i].size});
        chk($sformatf("v%0d_be", i),   {28'h0, bus_if.mem_be}, {28'h0, vec[i].exp_be});
        if (vec[i].we) chk($sformatf("v%0d_mwdata", i), bus_if.mem_wdata, vec[i].exp_wdata);
        chk($sformatf("v%0d_early_done", i), {31'h0, bus_if.lsu_done}, 32'd0);
        @(negedge clk);
      end else begin
        chk($sformatf("v%0d_no_req", i), {31'h0, bus_if.mem_req}, 32'd0);
      end
      chk($sformatf("v%0d_done", i),  {31'h0, bus_if.lsu_done}, 32'd1);
      chk($sformatf("v%0d_err", i),   {31'h0, bus_if.lsu_err}, {31'h0, vec[i].exp_err});
      chk($sformatf("v%0d_rdata", i), bus_if.lsu_rdata, vec[i].exp_rdata);
      chk($sformatf("v%0d_req_low", i), {31'h0, bus_if.mem_req}, 32'd0);
      chk($sformatf("v%0d_busy", i), {31'h0, bus_if.lsu_ready}, 32'd0);
    end

    // No grant at all: four request cycles, then an error completion
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0, 32'hA5A5A5A5);
    gnt_en = 1'b0;
    @(negedge clk);
    bus_if.lsu_valid = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < 20 && !bus_if.lsu_done; c++) begin
      if (bus_if.mem_req) req_cycles++;
      @(negedge clk);
    end
    chk("to_req_cycles", req_cycles, 32'd4);
    chk("to_done", {31'h0, bus_if.lsu_done}, 32'd1);
    chk("to_err",  {31'h0, bus_if.lsu_err},  32'd1);
    chk("to_req_low", {31'h0, bus_if.mem_req}, 32'd0);
    chk("to_rdata_held", bus_if.lsu_rdata, 32'h0000007F);

    // Grant arrives in the last allowed cycle: grant wins over timeout
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h00000020, 32'h0, 32'h11223344);
    @(negedge clk);
    bus_if.lsu_valid = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < 20 && !bus_if.lsu_done; c++) begin
      if (bus_if.mem_req) req_cycles++;
      if (req_cycles == 4) gnt_en = 1'b1;
      @(negedge clk);
    end
    gnt_en = 1'b0;
    chk("late_req_cycles", req_cycles, 32'd4);
    chk("late_done", {31'h0, bus_if.lsu_done}, 32'd1);
    chk("late_err",  {31'h0, bus_if.lsu_err},  32'd0);
    chk("late_rdata", bus_if.lsu_rdata, 32'h11223344);

    // Reset while a request is outstanding
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h00000040, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    bus_if.lsu_valid = 1'b0;
    chk("rq_req_before", {31'h0, bus_if.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rq_req_dropped", {30'h0, bus_if.mem_ce, bus_if.mem_req}, 32'd0);
    chk("rq_no_done", {31'h0, bus_if.lsu_done}, 32'd0);
    chk("rq_rdata_clr", bus_if.lsu_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rq_ready_after", {31'h0, bus_if.lsu_ready}, 32'd1);
      chk("rq_done_after",  {31'h0, bus_if.lsu_done},  32'd0);
    end

    // Recovery access after reset
    drive(1'b0, 2'b00, 1'b1, 32'h00000002, 32'h0, 32'h000000C3);
    gnt_en = 1'b1;
    @(negedge clk);
    bus_if.lsu_valid = 1'b0;
    @(negedge clk);
    chk("rec_done",  {31'h0, bus_if.lsu_done}, 32'd1);
    chk("rec_rdata", bus_if.lsu_rdata, 32'h000000C3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
